// File: rtl/ecc_scrub_controller.sv
// Single-port sequencer for the 16-entry Hamming SEC memory: host read/write plus background scrubber.
// Define ECC_SCRUB_WRITEBACK_EN to write corrected words back; otherwise scrubbing only counts errors.
module ecc_scrub_controller #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned SCRUB_INTERVAL = 64,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_sec,
    input  logic              scrub_enable,
    output logic [7:0]        err_count,
    output logic              scrub_pass_done,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = $clog2(SCRUB_INTERVAL);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST_WR,
        S_HOST_RD,
        S_SCRUB_RD,
        S_SCRUB_WB
    } state_t;

    state_t             r_state;
    logic               r_host_ack;
    logic [DATA_W-1:0]  r_host_rdata;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_mem_wr_en;
    logic [7:0]         r_err_count;
    logic               r_pass_done;
    logic               r_busy;
    logic [ADDR_W-1:0]  r_scrub_ptr;
    logic [STV_W-1:0]   r_starve_cnt;
    logic [CNT_W-1:0]   r_int_cnt;
    logic               r_scrub_due;

    state_t             w_state_d;
    logic               w_host_ack_d;
    logic [DATA_W-1:0]  w_host_rdata_d;
    logic [ADDR_W-1:0]  w_mem_addr_d;
    logic [DATA_W-1:0]  w_mem_wdata_d;
    logic               w_mem_wr_en_d;
    logic [7:0]         w_err_count_d;
    logic               w_pass_done_d;
    logic [ADDR_W-1:0]  w_scrub_ptr_d;
    logic [STV_W-1:0]   w_starve_cnt_d;
    logic               w_scrub_start;
    logic               w_ptr_inc;
    logic               w_int_last;

    assign w_int_last = (r_int_cnt == CNT_W'(SCRUB_INTERVAL - 1));

    // Interval timer; scrub_due latches until the arbiter launches a scrub.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_cnt   <= '0;
            r_scrub_due <= 1'b0;
        end else begin
            if (!scrub_enable || w_int_last) r_int_cnt <= '0;
            else                             r_int_cnt <= r_int_cnt + CNT_W'(1);
            if (scrub_enable && w_int_last)  r_scrub_due <= 1'b1;
            else if (w_scrub_start)          r_scrub_due <= 1'b0;
        end
    end

    // Next-state and next-output logic; every memory-side output is registered from these.
    always_comb begin
        w_state_d      = r_state;
        w_host_ack_d   = 1'b0;
        w_host_rdata_d = r_host_rdata;
        w_mem_addr_d   = r_mem_addr;
        w_mem_wdata_d  = r_mem_wdata;
        w_mem_wr_en_d  = 1'b0;
        w_err_count_d  = r_err_count;
        w_pass_done_d  = 1'b0;
        w_scrub_ptr_d  = r_scrub_ptr;
        w_starve_cnt_d = r_starve_cnt;
        w_scrub_start  = 1'b0;
        w_ptr_inc      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_scrub_due && scrub_enable &&
                    (!host_req || r_starve_cnt == STV_W'(STARVE_LIMIT))) begin
                    w_state_d      = S_SCRUB_RD;
                    w_mem_addr_d   = r_scrub_ptr;
                    w_starve_cnt_d = '0;
                    w_scrub_start  = 1'b1;
                end else if (host_req) begin
                    w_mem_addr_d = host_addr;
                    if (host_we) begin
                        w_state_d     = S_HOST_WR;
                        w_mem_wr_en_d = 1'b1;
                        w_mem_wdata_d = host_wdata;
                        w_host_ack_d  = 1'b1;
                    end else begin
                        w_state_d = S_HOST_RD;
                    end
                    if (r_scrub_due && r_starve_cnt != STV_W'(STARVE_LIMIT))
                        w_starve_cnt_d = r_starve_cnt + STV_W'(1);
                end
            end
            S_HOST_WR: w_state_d = S_IDLE;
            S_HOST_RD: begin
                w_host_rdata_d = mem_rdata;
                w_host_ack_d   = 1'b1;
                w_state_d      = S_IDLE;
            end
            S_SCRUB_RD: begin
                w_state_d = S_IDLE;
                if (mem_sec) begin
                    if (r_err_count != 8'hFF) w_err_count_d = r_err_count + 8'd1;
`ifdef ECC_SCRUB_WRITEBACK_EN
                    // mem_wdata doubles as the write-back buffer for the corrected word.
                    w_state_d     = S_SCRUB_WB;
                    w_mem_wr_en_d = 1'b1;
                    w_mem_wdata_d = mem_rdata;
`else
                    w_ptr_inc = 1'b1;
`endif
                end else begin
                    w_ptr_inc = 1'b1;
                end
            end
            S_SCRUB_WB: begin
                w_ptr_inc = 1'b1;
                w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase

        if (w_ptr_inc) begin
            w_scrub_ptr_d = r_scrub_ptr + ADDR_W'(1);
            w_pass_done_d = (r_scrub_ptr == ADDR_W'(DEPTH - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wr_en  <= 1'b0;
            r_err_count  <= '0;
            r_pass_done  <= 1'b0;
            r_busy       <= 1'b0;
            r_scrub_ptr  <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_d;
            r_host_ack   <= w_host_ack_d;
            r_host_rdata <= w_host_rdata_d;
            r_mem_addr   <= w_mem_addr_d;
            r_mem_wdata  <= w_mem_wdata_d;
            r_mem_wr_en  <= w_mem_wr_en_d;
            r_err_count  <= w_err_count_d;
            r_pass_done  <= w_pass_done_d;
            r_busy       <= (w_state_d != S_IDLE);
            r_scrub_ptr  <= w_scrub_ptr_d;
            r_starve_cnt <= w_starve_cnt_d;
        end
    end

    assign host_ack        = r_host_ack;
    assign host_rdata      = r_host_rdata;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign mem_wr_en       = r_mem_wr_en;
    assign err_count       = r_err_count;
    assign scrub_pass_done = r_pass_done;
    assign busy            = r_busy;

endmodule

// File: tb/tb_ecc_scrub_controller.sv
// Scoreboard bench for ecc_scrub_controller with a behavioural SEC memory whose fault heals on rewrite.
module tb_ecc_scrub_controller;

    logic       clk;
    logic       rst;
    logic       host_req;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wr_en;
    logic [7:0] mem_rdata;
    logic       mem_sec;
    logic       scrub_enable;
    logic [7:0] err_count;
    logic       scrub_pass_done;
    logic       busy;

`ifdef ECC_SCRUB_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } host_exp_t;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wb_exp_t;

    host_exp_t host_q[$];
    wb_exp_t   wb_q[$];
    host_exp_t mon_h;
    wb_exp_t   mon_w;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Memory model: returns corrected data, flags SEC at the armed address until that word is rewritten.
    logic [7:0] mem_arr [16];
    logic [3:0] fault_addr = 4'd0;
    logic       fault_on   = 1'b0;
    int         wr_hits    = 0;
    int         arm_hits   = 0;

    assign mem_rdata = mem_arr[mem_addr];
    assign mem_sec   = fault_on && (wr_hits == arm_hits) && (mem_addr == fault_addr);

    always @(posedge clk) begin
        if (mem_wr_en) mem_arr[mem_addr] <= mem_wdata;
        if (mem_wr_en && mem_addr == fault_addr) wr_hits <= wr_hits + 1;
    end

    ecc_scrub_controller #(
        .DATA_W(8), .ADDR_W(4), .SCRUB_INTERVAL(64), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata), .mem_sec(mem_sec),
        .scrub_enable(scrub_enable), .err_count(err_count),
        .scrub_pass_done(scrub_pass_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Host completions: writes must show the memory write in the ack cycle, reads the data.
    always @(negedge clk) begin
        if (host_ack) begin
            if (host_q.size() == 0) begin
                check("host_ack_unexpected", 32'(1), 32'(0));
            end else begin
                mon_h = host_q.pop_front();
                if (mon_h.we)
                    check("host_wr", 32'({mem_wr_en, mem_addr, mem_wdata}),
                          32'({1'b1, mon_h.addr, mon_h.data}));
                else
                    check("host_rd", 32'(host_rdata), 32'(mon_h.data));
            end
        end
    end

    // Scrubber write-backs: any memory write without a host ack must be an expected repair.
    always @(negedge clk) begin
        if (mem_wr_en && !host_ack) begin
            if (wb_q.size() == 0) begin
                check("scrub_wr_unexpected", 32'({mem_addr, mem_wdata}), 32'(0));
            end else begin
                mon_w = wb_q.pop_front();
                check("scrub_wb", 32'({mem_addr, mem_wdata}), 32'({mon_w.addr, mon_w.data}));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; scrub_enable = 1'b0; host_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic host_op(input logic we, input logic [3:0] a, input logic [7:0] d, input int exp_lat);
        host_exp_t e;
        int lat;
        lat = 0;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        e.we = we; e.addr = a; e.data = d;
        host_q.push_back(e);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (host_ack) begin
                lat = i;
                break;
            end
        end
        host_req = 1'b0;
        if (lat == 0) check("host_timeout", 32'(0), 32'(1));
        else if (exp_lat > 0) check(we ? "wr_latency" : "rd_latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int prev, gap, first_gap_idx, first_gap, other_bad, got;
        int n_scr, bad_addr, pulses, pulse_at;
        host_exp_t e;

        rst = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = 4'd0;
        host_wdata = 8'd0; scrub_enable = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({host_ack, host_rdata, mem_addr, mem_wdata, mem_wr_en,
                                    err_count, scrub_pass_done, busy}), 32'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Host traffic with exact latencies, including the top address.
        host_op(1'b1, 4'd0,  8'hA5, 2);
        host_op(1'b0, 4'd0,  8'hA5, 3);
        host_op(1'b1, 4'd7,  8'h3C, 2);
        host_op(1'b1, 4'd15, 8'hFF, 2);
        host_op(1'b1, 4'd3,  8'h5A, 2);
        host_op(1'b0, 4'd7,  8'h3C, 3);
        host_op(1'b0, 4'd15, 8'hFF, 3);
        host_op(1'b0, 4'd3,  8'h5A, 3);

        // Continuous reads: due at edge 64, four starved grants, clean scrub between acks 36 and 37.
        do_reset();
        @(posedge clk); #1;
        scrub_enable = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 4'd15;
        prev = 0; first_gap_idx = 0; first_gap = 0; other_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            e.we = 1'b0; e.addr = 4'd15; e.data = 8'hFF;
            host_q.push_back(e);
            got = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (host_ack) begin
                    got = 1;
                    break;
                end
            end
            if (got == 0) begin
                check("starve_timeout", 32'(0), 32'(1));
                break;
            end
            if (k > 1) begin
                gap = cyc - prev;
                if (gap != 2) begin
                    if (first_gap_idx == 0) begin
                        first_gap_idx = k;
                        first_gap     = gap;
                    end else begin
                        other_bad++;
                    end
                end
            end
            prev = cyc;
        end
        host_req = 1'b0; scrub_enable = 1'b0;
        check("starve_gap_index", 32'(first_gap_idx), 32'(37));
        check("starve_gap_len", 32'(first_gap), 32'(4));
        check("starve_other_gaps", 32'(other_bad), 32'(0));

        // Seventeen clean scrubs: addresses 0..15 then 0, one pass pulse after the 16th.
        do_reset();
        @(posedge clk); #1 scrub_enable = 1'b1;
        n_scr = 0; bad_addr = 0; pulses = 0; pulse_at = -1;
        for (int i = 0; i < 17 * 64 + 10; i++) begin
            @(negedge clk);
            if (busy && !mem_wr_en) begin
                if (mem_addr != 4'(n_scr % 16)) bad_addr++;
                n_scr++;
            end
            if (scrub_pass_done) begin
                pulses++;
                pulse_at = n_scr;
            end
        end
        scrub_enable = 1'b0;
        check("scrub_count", 32'(n_scr), 32'(17));
        check("scrub_addr_seq", 32'(bad_addr), 32'(0));
        check("pass_pulses", 32'(pulses), 32'(1));
        check("pass_pulse_pos", 32'(pulse_at), 32'(16));
        check("pass_err_count", 32'(err_count), 32'(0));

        // Correctable fault at address 0 found by the first scrub.
        do_reset();
        fault_addr = 4'd0; arm_hits = wr_hits; fault_on = 1'b1;
`ifdef ECC_SCRUB_WRITEBACK_EN
        wb_q.push_back('{addr: 4'd0, data: 8'hA5});
`endif
        @(posedge clk); #1 scrub_enable = 1'b1;
        repeat (67) @(posedge clk);
        @(negedge clk);
        check("fault0_err", 32'(err_count), 32'(1));
        check("fault0_wb_drained", 32'(wb_q.size()), 32'(0));
        fault_on = 1'b0;
        repeat (16 * 64 + 8) @(posedge clk);
        @(negedge clk);
        check("fault0_err_after_pass", 32'(err_count), 32'(1));
        scrub_enable = 1'b0;

        // Reset landing in SCRUB_RD of a faulted word drops the scrub entirely.
        do_reset();
        host_op(1'b0, 4'd15, 8'hFF, 3);
        fault_addr = 4'd0; arm_hits = wr_hits; fault_on = 1'b1;
        @(posedge clk); #1 scrub_enable = 1'b1;
        got = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (busy) begin
                got = 1;
                break;
            end
        end
        check("rst_scrub_seen", 32'({got[0], mem_addr, mem_wr_en}), 32'({1'b1, 4'd0, 1'b0}));
        rst = 1'b1; scrub_enable = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", 32'({host_ack, host_rdata, mem_addr, mem_wdata, mem_wr_en,
                                      err_count, scrub_pass_done, busy}), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        fault_on = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_err_count", 32'(err_count), 32'(0));

        // Fault at address 3 across two passes: repaired once with write-back, counted twice without.
        do_reset();
        fault_addr = 4'd3; arm_hits = wr_hits; fault_on = 1'b1;
`ifdef ECC_SCRUB_WRITEBACK_EN
        wb_q.push_back('{addr: 4'd3, data: 8'h5A});
`endif
        @(posedge clk); #1 scrub_enable = 1'b1;
        repeat (32 * 64 + 10) @(posedge clk);
        @(negedge clk);
        check("fault3_err_two_passes", 32'(err_count), WB_EN ? 32'(1) : 32'(2));
        scrub_enable = 1'b0; fault_on = 1'b0;

        repeat (4) @(posedge clk);
        check("host_q_empty", 32'(host_q.size()), 32'(0));
        check("wb_q_empty", 32'(wb_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
